// File: rtl/iitb_pkg.sv
// Shared types and constants for the IITB-RISC core: 16-bit words,
// fetch-queue entries, opcode encodings and the default reset PC.
package iitb_pkg;

   typedef logic [15:0] word_t;

   typedef struct packed {
      word_t pc;
      word_t instr;
   } fetch_entry_t;

   localparam word_t DEFAULT_RESET_PC = 16'h0000;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_ADI = 4'b0001;
   localparam logic [3:0] OP_NDU = 4'b0010;
   localparam logic [3:0] OP_LHI = 4'b0011;
   localparam logic [3:0] OP_LW  = 4'b0100;
   localparam logic [3:0] OP_SW  = 4'b0101;
   localparam logic [3:0] OP_BEQ = 4'b1100;
   localparam logic [3:0] OP_JAL = 4'b1000;
   localparam logic [3:0] OP_JLR = 4'b1001;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries with flush; QDEPTH must be a power of two
// so the pointers wrap naturally.
module fetch_queue
   import iitb_pkg::*;
#(
   parameter int QDEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_push,
   input  logic                         i_pop,
   input  logic                         i_flush,
   input  fetch_entry_t                 i_wdata,
   output fetch_entry_t                 o_rdata,
   output logic [$clog2(QDEPTH+1)-1:0]  o_count,
   output logic                         o_full,
   output logic                         o_empty
);

   localparam int PW = $clog2(QDEPTH);
   localparam int CW = $clog2(QDEPTH+1);

   fetch_entry_t   r_mem [QDEPTH];
   logic [PW-1:0]  r_head;
   logic [PW-1:0]  r_tail;
   logic [CW-1:0]  r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_tail <= r_tail + 1'b1;
         if (i_pop)  r_head <= r_head + 1'b1;
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries no reset; entries are only observed while counted valid.
   always_ff @(posedge clk) begin
      if (i_push && !i_flush) r_mem[r_tail] <= i_wdata;
   end

   assign o_rdata = r_mem[r_head];
   assign o_count = r_count;
   assign o_full  = (r_count == CW'(QDEPTH));
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, drives the async ROM and
// queues {pc, instr} for decode. Define FETCH_DBG_PORT_EN for the debug read port.
module fetch_ctrl
   import iitb_pkg::*;
#(
   parameter word_t RESET_PC = DEFAULT_RESET_PC,
   parameter int    QDEPTH   = 2
) (
   input  logic  clk,
   input  logic  rst,
   output word_t rom_addr,
   input  word_t rom_data,
   input  logic  redirect_valid,
   input  word_t redirect_pc,
   output logic  out_valid,
   input  logic  out_ready,
   output word_t out_instr,
   output word_t out_pc
`ifdef FETCH_DBG_PORT_EN
   ,
   input  logic  dbg_req,
   input  word_t dbg_addr,
   output logic  dbg_gnt,
   output logic  dbg_rvalid,
   output word_t dbg_rdata
`endif
);

   word_t                        r_fetch_pc;
   logic                         w_gnt;
   logic                         w_push;
   logic                         w_pop;
   logic                         w_full;
   logic                         w_empty;
   logic [$clog2(QDEPTH+1)-1:0]  w_count;
   fetch_entry_t                 w_wdata;
   fetch_entry_t                 w_head;

`ifdef FETCH_DBG_PORT_EN
   logic  r_dbg_rvalid;
   word_t r_dbg_rdata;

   assign w_gnt = dbg_req;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dbg_rvalid <= 1'b0;
         r_dbg_rdata  <= '0;
      end else begin
         r_dbg_rvalid <= w_gnt;
         if (w_gnt) r_dbg_rdata <= rom_data;
      end
   end

   assign dbg_gnt    = w_gnt;
   assign dbg_rvalid = r_dbg_rvalid;
   assign dbg_rdata  = r_dbg_rdata;
`else
   assign w_gnt = 1'b0;
`endif

   assign rom_addr = w_gnt ? dbg_addr_sel() : r_fetch_pc;

   // A redirect discards this cycle's pop; the redirecting stage owns the head.
   assign w_pop  = !w_empty && out_ready && !redirect_valid;
   assign w_push = !redirect_valid && !w_gnt && (!w_full || w_pop);

   assign w_wdata = '{pc: r_fetch_pc, instr: rom_data};

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 r_fetch_pc <= RESET_PC;
      else if (redirect_valid) r_fetch_pc <= redirect_pc;
      else if (w_push)         r_fetch_pc <= r_fetch_pc + 16'd1;
   end

   fetch_queue #(
      .QDEPTH (QDEPTH)
   ) u_queue (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (redirect_valid),
      .i_wdata (w_wdata),
      .o_rdata (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign out_valid = (w_count != '0);
   assign out_instr = w_head.instr;
   assign out_pc    = w_head.pc;

   function automatic word_t dbg_addr_sel();
`ifdef FETCH_DBG_PORT_EN
      return dbg_addr;
`else
      return r_fetch_pc;
`endif
   endfunction

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl; debug-port scenario runs when FETCH_DBG_PORT_EN is defined.
module tb_fetch_ctrl;
   import iitb_pkg::*;

   logic  clk = 1'b0;
   logic  rst;
   word_t rom_addr, rom_data;
   logic  redirect_valid;
   word_t redirect_pc;
   logic  out_valid, out_ready;
   word_t out_instr, out_pc;
`ifdef FETCH_DBG_PORT_EN
   logic  dbg_req, dbg_gnt, dbg_rvalid;
   word_t dbg_addr, dbg_rdata;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   function automatic word_t rom_f(input word_t a);
      return (a * 16'd7) ^ 16'h5A00;
   endfunction

   assign rom_data = rom_f(rom_addr);

   fetch_ctrl #(.RESET_PC(16'h0000), .QDEPTH(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc)
`ifdef FETCH_DBG_PORT_EN
      ,
      .dbg_req        (dbg_req),
      .dbg_addr       (dbg_addr),
      .dbg_gnt        (dbg_gnt),
      .dbg_rvalid     (dbg_rvalid),
      .dbg_rdata      (dbg_rdata)
`endif
   );

   task automatic test_reset();
      rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
`ifdef FETCH_DBG_PORT_EN
      dbg_req = 1'b0; dbg_addr = '0;
`endif
      repeat (2) @(negedge clk);
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", out_valid); end
      n_vec++; if (rom_addr !== 16'h0000) begin n_err++; $display("FAIL rst_rom_addr got %h exp 0000", rom_addr); end
`ifdef FETCH_DBG_PORT_EN
      n_vec++; if (dbg_gnt !== 1'b0) begin n_err++; $display("FAIL rst_dbg_gnt got %b exp 0", dbg_gnt); end
      n_vec++; if (dbg_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_dbg_rvalid got %b exp 0", dbg_rvalid); end
      n_vec++; if (dbg_rdata !== 16'h0000) begin n_err++; $display("FAIL rst_dbg_rdata got %h exp 0000", dbg_rdata); end
`endif
      rst = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL first_valid got %b exp 1", out_valid); end
      n_vec++; if (out_pc !== 16'h0000) begin n_err++; $display("FAIL first_pc got %h exp 0000", out_pc); end
      n_vec++; if (out_instr !== rom_f(16'h0000)) begin n_err++; $display("FAIL first_instr got %h exp %h", out_instr, rom_f(16'h0000)); end
   endtask

   task automatic test_stream();
      for (int k = 1; k <= 18; k++) begin
         @(negedge clk);
         n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid k=%0d got %b exp 1", k, out_valid); end
         n_vec++; if (out_pc !== word_t'(k)) begin n_err++; $display("FAIL stream_pc got %h exp %h", out_pc, word_t'(k)); end
         n_vec++; if (out_instr !== rom_f(word_t'(k))) begin n_err++; $display("FAIL stream_instr got %h exp %h", out_instr, rom_f(word_t'(k))); end
      end
   endtask

   task automatic test_backpressure();
      rst = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid got %b exp 1", out_valid); end
      n_vec++; if (rom_addr !== 16'h0002) begin n_err++; $display("FAIL bp_fetch_pc got %h exp 0002", rom_addr); end
      n_vec++; if (out_pc !== 16'h0000) begin n_err++; $display("FAIL bp_head_pc got %h exp 0000", out_pc); end
      out_ready = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         n_vec++; if (out_pc !== word_t'(k) || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_drain_pc got %h/%b exp %h/1", out_pc, out_valid, word_t'(k)); end
         n_vec++; if (out_instr !== rom_f(word_t'(k))) begin n_err++; $display("FAIL bp_drain_instr got %h exp %h", out_instr, rom_f(word_t'(k))); end
      end
   endtask

   task automatic test_redirect_full();
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      redirect_valid = 1'b1; redirect_pc = 16'h000F; out_ready = 1'b1;
      @(negedge clk);
      redirect_valid = 1'b0;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush_valid got %b exp 0", out_valid); end
      n_vec++; if (rom_addr !== 16'h000F) begin n_err++; $display("FAIL redir_rom_addr got %h exp 000f", rom_addr); end
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b1 || out_pc !== 16'h000F) begin n_err++; $display("FAIL redir_pc got %h/%b exp 000f/1", out_pc, out_valid); end
      n_vec++; if (out_instr !== rom_f(16'h000F)) begin n_err++; $display("FAIL redir_instr got %h exp %h", out_instr, rom_f(16'h000F)); end
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b1 || out_pc !== 16'h0010) begin n_err++; $display("FAIL redir_next_pc got %h/%b exp 0010/1", out_pc, out_valid); end
   endtask

   task automatic test_wrap();
      redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
      @(negedge clk);
      redirect_valid = 1'b0;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL wrap_flush_valid got %b exp 0", out_valid); end
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b1 || out_pc !== 16'hFFFF) begin n_err++; $display("FAIL wrap_pc0 got %h/%b exp ffff/1", out_pc, out_valid); end
      n_vec++; if (out_instr !== rom_f(16'hFFFF)) begin n_err++; $display("FAIL wrap_instr got %h exp %h", out_instr, rom_f(16'hFFFF)); end
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b1 || out_pc !== 16'h0000) begin n_err++; $display("FAIL wrap_pc1 got %h/%b exp 0000/1", out_pc, out_valid); end
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b1 || out_pc !== 16'h0001) begin n_err++; $display("FAIL wrap_pc2 got %h/%b exp 0001/1", out_pc, out_valid); end
   endtask

`ifdef FETCH_DBG_PORT_EN
   task automatic test_debug();
      // Head is PC 1 and fetch_pc is 2 on entry.
      dbg_req = 1'b1; dbg_addr = 16'h0008;
      #1;
      n_vec++; if (dbg_gnt !== 1'b1) begin n_err++; $display("FAIL dbg_gnt got %b exp 1", dbg_gnt); end
      n_vec++; if (rom_addr !== 16'h0008) begin n_err++; $display("FAIL dbg_rom_addr got %h exp 0008", rom_addr); end
      @(negedge clk);
      dbg_req = 1'b0;
      n_vec++; if (dbg_rvalid !== 1'b1) begin n_err++; $display("FAIL dbg_rvalid got %b exp 1", dbg_rvalid); end
      n_vec++; if (dbg_rdata !== rom_f(16'h0008)) begin n_err++; $display("FAIL dbg_rdata got %h exp %h", dbg_rdata, rom_f(16'h0008)); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL dbg_bubble got %b exp 0", out_valid); end
      @(negedge clk);
      n_vec++; if (dbg_rvalid !== 1'b0) begin n_err++; $display("FAIL dbg_rvalid_pulse got %b exp 0", dbg_rvalid); end
      n_vec++; if (out_valid !== 1'b1 || out_pc !== 16'h0002) begin n_err++; $display("FAIL dbg_resume_pc got %h/%b exp 0002/1", out_pc, out_valid); end
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b1 || out_pc !== 16'h0003) begin n_err++; $display("FAIL dbg_next_pc got %h/%b exp 0003/1", out_pc, out_valid); end
   endtask
`endif

   task automatic test_reset_mid();
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got %b exp 0", out_valid); end
      n_vec++; if (rom_addr !== 16'h0000) begin n_err++; $display("FAIL rstmid_rom_addr got %h exp 0000", rom_addr); end
      @(negedge clk);
      rst = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b1 || out_pc !== 16'h0000) begin n_err++; $display("FAIL rstmid_pc0 got %h/%b exp 0000/1", out_pc, out_valid); end
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b1 || out_pc !== 16'h0001) begin n_err++; $display("FAIL rstmid_pc1 got %h/%b exp 0001/1", out_pc, out_valid); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_full();
      test_wrap();
`ifdef FETCH_DBG_PORT_EN
      test_debug();
`endif
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
